shared_var_resolver: RTL and testbench

//  Resolves N same-cycle writers to one shared variable (highest index wins, i.e. last assignment wins).

---
 rtl/shared_var_resolver.sv | 162 ++++++++++++++++
 tb/tb_shared_var_resolver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/shared_var_resolver.sv
// Merges same-cycle writes to one shared variable (the highest-index writer wins) and counts collisions.
// Each committed update is queued to a single reader through a 2-entry buffer. Optional macro: SHARED_VAR_XMASK_EN.
module shared_var_resolver #(
  parameter int NUM_WR = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        value_o,
  output logic                     conflict_o,
  output logic [CNT_W-1:0]         conflict_cnt_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     overflow_o,
  output logic [DATA_W-1:0]        x_mask_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

  logic              any_wr;
  logic [DATA_W-1:0] win_data;
  logic [NUM_WR-1:0] differs;
  logic              conflict_now;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] value_q, value_d;
  logic              conflict_q, conflict_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  buf_state_t        state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              ovf_q, ovf_d;

  // Later iterations overwrite earlier ones, so the highest asserted index wins.
  always_comb begin
    any_wr   = 1'b0;
    win_data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) begin
        any_wr   = 1'b1;
        win_data = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A collision exists exactly when some asserted writer disagrees with the winner.
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_diff
    assign differs[gi] = wr_en[gi] && (wr_data[gi*DATA_W +: DATA_W] != win_data);
  end
  assign conflict_now = |differs;

  assign push = any_wr;
  assign pop  = (state_q != EMPTY) && rd_ready_i;

  always_comb begin
    value_d    = any_wr ? win_data : value_q;
    conflict_d = conflict_now;
    cnt_d      = cnt_q;
    if (conflict_now && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ovf_d   = ovf_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = win_data;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
          tail_d  = win_data;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          head_d = win_data;
        end
      end
      TWO: begin
        if (pop && !push) begin
          state_d = ONE;
          head_d  = tail_q;
        end else if (push && pop) begin
          head_d = tail_q;
          tail_d = win_data;
        end else if (push && !pop) begin
          // Full and nobody reading: keep the oldest, replace the newest.
          tail_d = win_data;
          ovf_d  = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q    <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      value_q    <= value_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef SHARED_VAR_XMASK_EN
  logic [DATA_W-1:0] seen_one;
  logic [DATA_W-1:0] seen_zero;
  logic [DATA_W-1:0] xmask_q, xmask_d;

  always_comb begin
    seen_one  = '0;
    seen_zero = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) begin
        seen_one  = seen_one | wr_data[i*DATA_W +: DATA_W];
        seen_zero = seen_zero | ~wr_data[i*DATA_W +: DATA_W];
      end
    end
    xmask_d = any_wr ? (seen_one & seen_zero) : xmask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) xmask_q <= '0;
    else     xmask_q <= xmask_d;
  end

  assign x_mask_o = xmask_q;
`else
  assign x_mask_o = '0;
`endif

  assign value_o        = value_q;
  assign conflict_o     = conflict_q;
  assign conflict_cnt_o = cnt_q;
  assign rd_valid_o     = (state_q != EMPTY);
  assign rd_data_o      = head_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_shared_var_resolver.sv
// Directed bench for shared_var_resolver: a queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_shared_var_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [7:0]  value_o;
  logic        conflict_o;
  logic [7:0]  conflict_cnt_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [7:0]  rd_data_o;
  logic        overflow_o;
  logic [7:0]  x_mask_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  shared_var_resolver #(.NUM_WR(4), .DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .value_o(value_o), .conflict_o(conflict_o), .conflict_cnt_o(conflict_cnt_o),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .overflow_o(overflow_o), .x_mask_o(x_mask_o)
  );

  always #5 clk = ~clk;

  // Reference model.
  logic [7:0] m_value;
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_conf;
  int         m_cnt;
  logic [7:0] m_xmask;

  always @(posedge clk) begin
    logic [7:0] win;
    logic [7:0] dis;
    bit         any;
    bit         pop;
    if (rst) begin
      m_value = 8'h00; m_q.delete(); m_ovf = 0; m_conf = 0; m_cnt = 0; m_xmask = 8'h00;
    end else begin
      any = 0; win = 8'h00;
      for (int i = 0; i < 4; i++) if (wr_en[i]) begin any = 1; win = wr_data[i*8 +: 8]; end
      dis = 8'h00;
      for (int i = 0; i < 4; i++) if (wr_en[i]) dis = dis | (wr_data[i*8 +: 8] ^ win);
      pop = (m_q.size() > 0) && rd_ready_i;
      if (pop) void'(m_q.pop_front());
      if (any) begin
        m_value = win;
        if (m_q.size() == 2) begin m_q[1] = win; m_ovf = 1; end
        else m_q.push_back(win);
        m_xmask = dis;
      end
      m_conf = (dis != 8'h00);
      if (m_conf && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("value", value_o, m_value);
      chk("conflict", conflict_o, m_conf);
      chk("cnt", conflict_cnt_o, m_cnt);
      chk("rd_valid", rd_valid_o, m_q.size() > 0);
      if (m_q.size() > 0) chk("rd_data", rd_data_o, m_q[0]);
      chk("overflow", overflow_o, m_ovf);
`ifdef SHARED_VAR_XMASK_EN
      chk("x_mask", x_mask_o, m_xmask);
`else
      chk("x_mask", x_mask_o, 0);
`endif
    end
  end

  task automatic cyc(input logic [3:0] en, input logic [31:0] d, input logic rdy, input logic r);
    wr_en = en; wr_data = d; rd_ready_i = rdy; rst = r;
    @(posedge clk); #1;
    $display("t=%0t en=%b data=%h rdy=%b rst=%b -> value=%h conf=%b cnt=%0d valid=%b rd=%h ovf=%b xm=%h",
             $time, en, d, rdy, r, value_o, conflict_o, conflict_cnt_o, rd_valid_o, rd_data_o, overflow_o, x_mask_o);
  endtask

  logic [7:0] xm_t1;
  logic [7:0] xm_t5;

  initial begin
`ifdef SHARED_VAR_XMASK_EN
    xm_t1 = 8'h01; xm_t5 = 8'hFF;
`else
    xm_t1 = 8'h00; xm_t5 = 8'h00;
`endif
    wr_en = 0; wr_data = 0; rd_ready_i = 0; rst = 1;
    @(posedge clk); #1;
    cyc(4'b0000, 32'h0, 1'b0, 1'b1);
    cmp_en = 1'b1;
    chk("reset_value", value_o, 8'h00);
    chk("reset_valid", rd_valid_o, 1'b0);
    chk("reset_cnt", conflict_cnt_o, 8'h00);
    chk("reset_ovf", overflow_o, 1'b0);

    // T1
    cyc(4'b0011, 32'h0000_0100, 1'b0, 1'b0);
    chk("t1_value", value_o, 8'h01);
    chk("t1_conflict", conflict_o, 1'b1);
    chk("t1_cnt", conflict_cnt_o, 8'h01);
    chk("t1_xmask", x_mask_o, xm_t1);
    cyc(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t1_pop_empty", rd_valid_o, 1'b0);
    chk("t1_conf_pulse", conflict_o, 1'b0);

    // T2
    cyc(4'b1010, 32'hA500_A500, 1'b0, 1'b0);
    chk("t2_value", value_o, 8'hA5);
    chk("t2_conflict", conflict_o, 1'b0);
    chk("t2_cnt", conflict_cnt_o, 8'h01);
    chk("t2_valid", rd_valid_o, 1'b1);
    chk("t2_rd", rd_data_o, 8'hA5);
    chk("t2_xmask", x_mask_o, 8'h00);
    cyc(4'b0000, 32'h0, 1'b1, 1'b0);

    // T3
    cyc(4'b0001, 32'h0000_0011, 1'b0, 1'b0);
    cyc(4'b0001, 32'h0000_0022, 1'b0, 1'b0);
    cyc(4'b0001, 32'h0000_0033, 1'b0, 1'b0);
    chk("t3_ovf", overflow_o, 1'b1);
    chk("t3_head", rd_data_o, 8'h11);
    cyc(4'b0000, 32'h0, 1'b0, 1'b0);
    chk("t3_stable", rd_data_o, 8'h11);
    cyc(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t3_second", rd_data_o, 8'h33);
    chk("t3_second_valid", rd_valid_o, 1'b1);
    cyc(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t3_drained", rd_valid_o, 1'b0);
    chk("t3_ovf_sticky", overflow_o, 1'b1);

    // T4
    cyc(4'b0000, 32'h0, 1'b0, 1'b1);
    cyc(4'b0100, 32'h0040_0000, 1'b0, 1'b0);
    cyc(4'b0100, 32'h0041_0000, 1'b0, 1'b0);
    chk("t4_full_head", rd_data_o, 8'h40);
    cyc(4'b0100, 32'h0042_0000, 1'b1, 1'b0);
    chk("t4_head", rd_data_o, 8'h41);
    chk("t4_ovf", overflow_o, 1'b0);
    cyc(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t4_tail", rd_data_o, 8'h42);
    cyc(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t4_empty", rd_valid_o, 1'b0);

    // T5
    for (int i = 0; i < 260; i++) begin
      cyc(4'b0011, 32'h0000_FF00, 1'b1, 1'b0);
      if (i == 253) chk("t5_cnt_254", conflict_cnt_o, 8'hFE);
    end
    chk("t5_sat", conflict_cnt_o, 8'hFF);
    chk("t5_xmask", x_mask_o, xm_t5);
    cyc(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t5_hold_cnt", conflict_cnt_o, 8'hFF);
    chk("t5_hold_xmask", x_mask_o, xm_t5);
    chk("t5_conf_drop", conflict_o, 1'b0);

    // T6
    cyc(4'b0001, 32'h0000_0001, 1'b0, 1'b0);
    cyc(4'b0001, 32'h0000_0002, 1'b0, 1'b0);
    cyc(4'b1111, 32'h1234_5678, 1'b0, 1'b1);
    chk("t6_value", value_o, 8'h00);
    chk("t6_valid", rd_valid_o, 1'b0);
    chk("t6_cnt", conflict_cnt_o, 8'h00);
    chk("t6_ovf", overflow_o, 1'b0);
    chk("t6_conf", conflict_o, 1'b0);
    chk("t6_xmask", x_mask_o, 8'h00);
    cyc(4'b0000, 32'h0, 1'b0, 1'b0);
    chk("t6_after", rd_valid_o, 1'b0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
